// File: rtl/mem_bus_pkg.sv
// Shared definitions for the on-chip RAM bus: default widths, write-size codes
// and the arbiter state encoding.
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 32;

    localparam logic [1:0] WSIZE_BYTE = 2'b01;
    localparam logic [1:0] WSIZE_HALF = 2'b10;
    localparam logic [1:0] WSIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the port that
// was not served last wins.
module rr_pick2 (
    input  logic       last,
    input  logic [1:0] req,
    output logic [1:0] pick
);

    // One-hot choice from the request pair and the last-served port
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported RAM between two bus masters: zero-latency
// round-robin grant with an atomic lock, and routing of read data to its owner.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          m_req,
    input  logic [1:0]          m_lock,
    input  logic [1:0]          m_wen,
    input  logic [2*ADDR_W-1:0] m_addr,
    input  logic [2*DATA_W-1:0] m_wdata,
    input  logic [3:0]          m_wsize,
    output logic [1:0]          m_gnt,
    output logic [1:0]          m_rvalid,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [1:0]          mem_wsize,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e state_r;
    arb_state_e state_n_s;
    logic       last_r;
    logic       last_n_s;
    logic [1:0] rd_owner_r;
    logic [1:0] rd_owner_n_s;
    logic [1:0] pick_s;
    logic [1:0] gnt_s;
    logic [1:0] acc_s;
    logic       wen_sel_s;

    rr_pick2 u_pick (
        .last (last_r),
        .req  (m_req),
        .pick (pick_s)
    );

    // Grant: round-robin in IDLE, only the lock owner while locked
    always_comb begin
        gnt_s = 2'b00;
        if (reset) begin
            gnt_s = 2'b00;
        end else begin
            case (state_r)
                IDLE:    gnt_s = pick_s;
                LOCK0:   gnt_s = {1'b0, m_req[0]};
                LOCK1:   gnt_s = {m_req[1], 1'b0};
                default: gnt_s = 2'b00;
            endcase
        end
    end

    assign acc_s = m_req & gnt_s;
    assign m_gnt = gnt_s;

    // Next state, last-served pointer and read owner from the accepted port
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_s[0] && m_lock[0]) begin
                    state_n_s = LOCK0;
                end else if (acc_s[1] && m_lock[1]) begin
                    state_n_s = LOCK1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            LOCK0: begin
                if (acc_s[0] && !m_lock[0]) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = LOCK0;
                end
            end
            LOCK1: begin
                if (acc_s[1] && !m_lock[1]) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = LOCK1;
                end
            end
            default: state_n_s = IDLE;
        endcase

        if (|acc_s) begin
            last_n_s = acc_s[1];
        end else begin
            last_n_s = last_r;
        end

        rd_owner_n_s = acc_s & ~m_wen;
    end

    // State, pointer and read-owner registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            last_r     <= 1'b1;
            rd_owner_r <= 2'b00;
        end else begin
            state_r    <= state_n_s;
            last_r     <= last_n_s;
            rd_owner_r <= rd_owner_n_s;
        end
    end

    // Memory drive follows the accepted port; port 0 is the idle default
    always_comb begin
        if (acc_s[1]) begin
            mem_addr  = m_addr[ADDR_W +: ADDR_W];
            mem_wdata = m_wdata[DATA_W +: DATA_W];
            mem_wsize = m_wsize[3:2];
            wen_sel_s = m_wen[1];
        end else begin
            mem_addr  = m_addr[0 +: ADDR_W];
            mem_wdata = m_wdata[0 +: DATA_W];
            mem_wsize = m_wsize[1:0];
            wen_sel_s = m_wen[0];
        end
        mem_ren = (|acc_s) & ~wen_sel_s;
        mem_wen = (|acc_s) & wen_sel_s;
    end

    // Read return; a read in flight when reset arrives is dropped
    always_comb begin
        if (reset) begin
            m_rvalid = 2'b00;
        end else begin
            m_rvalid = rd_owner_r;
        end
        m_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked
// against a rule-level arbitration model and a read-return scoreboard.
module tb_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    m_req, m_lock, m_wen;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [3:0]    m_wsize;
    logic [1:0]    m_gnt, m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ren, mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_wsize;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_lock(m_lock), .m_wen(m_wen),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wsize(m_wsize),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wsize(mem_wsize), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [31:0] stub_mem [0:63];
    logic [31:0] ref_mem  [0:63];

    // Byte-lane merge used by the RAM stub and the reference memory alike
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lane,
                                          input logic [31:0] wd, input logic [1:0] ws);
        logic [31:0] r;
        r = old;
        case (ws)
            2'b01:   r[lane*8 +: 8] = wd[7:0];
            2'b10:   r[lane[1]*16 +: 16] = wd[15:0];
            2'b11:   r = wd;
            default: r = old;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Single-ported RAM stub with one-cycle registered read; cleared by reset
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) stub_mem[i] <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_wen) stub_mem[mem_addr[7:2]] <= merge(stub_mem[mem_addr[7:2]], mem_addr[1:0], mem_wdata, mem_wsize);
            if (mem_ren) mem_rdata <= stub_mem[mem_addr[7:2]];
        end
    end

    // Reference model: expected grant and memory drive from the arbitration rules
    initial begin
        int lock_owner;
        int last_port;
        int k;
        logic [1:0]  exp_g;
        logic [49:0] exp_mem;
        logic [13:0] a;
        lock_owner = -1;
        last_port  = 1;
        forever begin
            @(negedge clk);
            k = -1;
            if (reset) begin
                lock_owner = -1;
                last_port  = 1;
                for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
            end else if (lock_owner >= 0) begin
                if (m_req[lock_owner]) k = lock_owner;
            end else if (m_req == 2'b11) begin
                k = 1 - last_port;
            end else if (m_req[0]) begin
                k = 0;
            end else if (m_req[1]) begin
                k = 1;
            end
            exp_g = 2'b00;
            if (k >= 0) exp_g[k] = 1'b1;
            check("gnt", {62'h0, m_gnt}, {62'h0, exp_g});

            if (k == 1) exp_mem = {m_addr[AW +: AW], m_wdata[DW +: DW], m_wsize[3:2], !m_wen[1], m_wen[1]};
            else if (k == 0) exp_mem = {m_addr[0 +: AW], m_wdata[0 +: DW], m_wsize[1:0], !m_wen[0], m_wen[0]};
            else exp_mem = {m_addr[0 +: AW], m_wdata[0 +: DW], m_wsize[1:0], 1'b0, 1'b0};
            check("mem_drive", {14'h0, mem_addr, mem_wdata, mem_wsize, mem_ren, mem_wen}, {14'h0, exp_mem});

            if (k >= 0) begin
                a = m_addr[k*AW +: AW];
                last_port = k;
                if (lock_owner < 0 && m_lock[k]) lock_owner = k;
                else if (lock_owner == k && !m_lock[k]) lock_owner = -1;
                if (m_wen[k]) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], a[1:0], m_wdata[k*DW +: DW], m_wsize[k*2 +: 2]);
                else rd_q.push_back('{due: cyc + 1, port: k, data: ref_mem[a[7:2]]});
            end
        end
    end

    // Monitor: read returns must appear exactly one cycle after their accept
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                e = rd_q.pop_front();
                if (reset) begin
                    check("rvalid_in_reset", {62'h0, m_rvalid}, 64'h0);
                end else begin
                    check("rvalid", {62'h0, m_rvalid}, 64'h1 << e.port);
                    check("rdata", {32'h0, m_rdata}, {32'h0, e.data});
                end
            end else begin
                check("rvalid_quiet", {62'h0, m_rvalid}, 64'h0);
            end
        end
    end

    task automatic setp(input int k, input logic rq, input logic lk, input logic we,
                        input logic [13:0] a, input logic [31:0] d, input logic [1:0] ws);
        m_req[k]              = rq;
        m_lock[k]             = lk;
        m_wen[k]              = we;
        m_addr[k*AW +: AW]    = a;
        m_wdata[k*DW +: DW]   = d;
        m_wsize[k*2 +: 2]     = ws;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus: directed scenarios, then randomized traffic honouring req/gnt
    initial begin
        logic [1:0] acc;
        reset = 1'b1;
        m_req = 2'b00; m_lock = 2'b00; m_wen = 2'b00;
        m_addr = '0; m_wdata = '0; m_wsize = 4'hF;
        step();
        setp(0, 1'b1, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        setp(1, 1'b1, 1'b0, 1'b0, 14'h0004, 32'h0, 2'b11);
        step(); step();
        reset = 1'b0;
        step();                                   // port 0 wins the first tie
        setp(0, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        step();
        setp(1, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);

        setp(0, 1'b1, 1'b0, 1'b1, 14'h0010, 32'hDEADBEEF, 2'b11);
        step();
        setp(0, 1'b1, 1'b0, 1'b0, 14'h0010, 32'h0, 2'b11);
        step();
        setp(0, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        step();

        setp(1, 1'b1, 1'b0, 1'b1, 14'h0030, 32'h12345678, 2'b11);
        step();
        setp(0, 1'b1, 1'b0, 1'b0, 14'h0010, 32'h0, 2'b11);
        setp(1, 1'b1, 1'b0, 1'b0, 14'h0030, 32'h0, 2'b11);
        repeat (6) step();
        setp(0, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        setp(1, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        step();

        setp(0, 1'b1, 1'b0, 1'b0, 14'h0010, 32'h0, 2'b11);
        step();
        setp(0, 1'b1, 1'b0, 1'b0, 14'h0014, 32'h0, 2'b11);
        setp(1, 1'b1, 1'b1, 1'b0, 14'h0020, 32'h0, 2'b11);
        step();                                   // locked read by port 1
        setp(1, 1'b1, 1'b0, 1'b1, 14'h0020, 32'h000000A5, 2'b01);
        step();                                   // unlocking byte write
        setp(1, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        step();
        setp(0, 1'b1, 1'b0, 1'b0, 14'h0020, 32'h0, 2'b11);
        step();
        setp(0, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);

        setp(1, 1'b1, 1'b1, 1'b0, 14'h0010, 32'h0, 2'b11);
        step();                                   // enter LOCK1, read in flight
        reset = 1'b1;
        setp(0, 1'b1, 1'b0, 1'b0, 14'h0010, 32'h0, 2'b11);
        setp(1, 1'b1, 1'b0, 1'b0, 14'h0020, 32'h0, 2'b11);
        step();
        reset = 1'b0;
        step();
        setp(0, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        setp(1, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        step();

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = m_req & m_gnt;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!m_req[p] || acc[p]) begin
                    if ($urandom_range(0, 3) != 0)
                        setp(p, 1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                             14'($urandom_range(0, 255)), $urandom(), 2'($urandom_range(1, 3)));
                    else
                        setp(p, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
                end
            end
        end

        reset = 1'b0;
        setp(0, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        setp(1, 1'b0, 1'b0, 1'b0, 14'h0000, 32'h0, 2'b11);
        repeat (3) step();
        check("drain", 64'(rd_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
